// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer: turns scanner key strobes into a packed-BCD entry
// with backspace/clear/enter, an inactivity timeout and a valid/ack handoff.
module key_entry_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TIMEOUT_CYC = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [3:0]            KEY_Value,
  input  logic                  Value_en,
  input  logic                  ENTRY_ACK,
  output logic [4*DIGITS-1:0]   ENTRY_BCD,
  output logic [3:0]            ENTRY_LEN,
  output logic                  ENTRY_VALID,
  output logic                  KEY_ACCEPT,
  output logic                  KEY_REJECT,
  output logic                  TIMEOUT
);

  localparam int unsigned       BCD_W    = 4 * DIGITS;
  localparam logic [3:0]        MAX_LEN  = 4'(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [3:0] KEY_BKSP  = 4'd10;
  localparam logic [3:0] KEY_CLR   = 4'd11;
  localparam logic [3:0] KEY_ENTER = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_nxt;
  logic               en_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [3:0]         len_nxt;
  logic               acc_nxt;
  logic               rej_nxt;
  logic               tmo_nxt;

  logic key_evt;
  logic is_digit;
  logic is_bksp;
  logic is_clr;
  logic is_enter;
  logic room;
  logic empty;
  logic expire;

  // Key event is the rising edge of the scanner strobe
  assign key_evt  = Value_en & ~en_q;
  assign is_digit = (KEY_Value <= 4'd9);
  assign is_bksp  = (KEY_Value == KEY_BKSP);
  assign is_clr   = (KEY_Value == KEY_CLR);
  assign is_enter = (KEY_Value == KEY_ENTER);
  assign room     = (ENTRY_LEN < MAX_LEN);
  assign empty    = (ENTRY_LEN == 4'd0);
  // A key event in the expiry cycle takes priority over the timeout
  assign expire   = (state_q == S_ENTRY) && !key_evt && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (key_evt) begin
          if (is_digit && room) begin
            state_nxt = S_ENTRY;
          end else if (is_bksp && !empty) begin
            state_nxt = (ENTRY_LEN == 4'd1) ? S_IDLE : S_ENTRY;
          end else if (is_clr) begin
            state_nxt = S_IDLE;
          end else if (is_enter && (state_q == S_ENTRY)) begin
            state_nxt = S_DONE;
          end
        end else if (expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        if (ENTRY_ACK) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    bcd_nxt = ENTRY_BCD;
    len_nxt = ENTRY_LEN;
    acc_nxt = 1'b0;
    rej_nxt = 1'b0;
    tmo_nxt = 1'b0;
    cnt_nxt = '0;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (key_evt) begin
          if (is_digit) begin
            if (room) begin
              bcd_nxt = (ENTRY_BCD << 4) | BCD_W'(KEY_Value);
              len_nxt = ENTRY_LEN + 4'd1;
              acc_nxt = 1'b1;
            end else begin
              rej_nxt = 1'b1;
            end
          end else if (is_bksp) begin
            if (!empty) begin
              bcd_nxt = ENTRY_BCD >> 4;
              len_nxt = ENTRY_LEN - 4'd1;
              acc_nxt = 1'b1;
            end else begin
              rej_nxt = 1'b1;
            end
          end else if (is_clr) begin
            bcd_nxt = '0;
            len_nxt = 4'd0;
            acc_nxt = 1'b1;
          end else if (is_enter && (state_q == S_ENTRY)) begin
            acc_nxt = 1'b1;
          end else begin
            rej_nxt = 1'b1;
          end
        end else if (expire) begin
          bcd_nxt = '0;
          len_nxt = 4'd0;
          tmo_nxt = 1'b1;
        end else if (state_q == S_ENTRY) begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        rej_nxt = key_evt;
        if (ENTRY_ACK) begin
          bcd_nxt = '0;
          len_nxt = 4'd0;
        end
      end
      default: begin
        bcd_nxt = '0;
        len_nxt = 4'd0;
      end
    endcase
  end

  // Registered outputs, strobe history and idle counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      en_q        <= 1'b0;
      cnt_q       <= '0;
      ENTRY_BCD   <= '0;
      ENTRY_LEN   <= 4'd0;
      ENTRY_VALID <= 1'b0;
      KEY_ACCEPT  <= 1'b0;
      KEY_REJECT  <= 1'b0;
      TIMEOUT     <= 1'b0;
    end else begin
      en_q        <= Value_en;
      cnt_q       <= cnt_nxt;
      ENTRY_BCD   <= bcd_nxt;
      ENTRY_LEN   <= len_nxt;
      ENTRY_VALID <= (state_nxt == S_DONE);
      KEY_ACCEPT  <= acc_nxt;
      KEY_REJECT  <= rej_nxt;
      TIMEOUT     <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed self-checking bench for key_entry_ctrl (DIGITS=4, TIMEOUT_CYC=16).
module tb_key_entry_ctrl;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned CNT_W       = 5;

  logic                CLK;
  logic                nRST;
  logic [3:0]          KEY_Value;
  logic                Value_en;
  logic                ENTRY_ACK;
  logic [4*DIGITS-1:0] ENTRY_BCD;
  logic [3:0]          ENTRY_LEN;
  logic                ENTRY_VALID;
  logic                KEY_ACCEPT;
  logic                KEY_REJECT;
  logic                TIMEOUT;

  int checks;
  int failures;
  logic p_acc;
  logic p_rej;
  logic p_tmo;

  key_entry_ctrl #(
    .DIGITS      (DIGITS),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .KEY_Value   (KEY_Value),
    .Value_en    (Value_en),
    .ENTRY_ACK   (ENTRY_ACK),
    .ENTRY_BCD   (ENTRY_BCD),
    .ENTRY_LEN   (ENTRY_LEN),
    .ENTRY_VALID (ENTRY_VALID),
    .KEY_ACCEPT  (KEY_ACCEPT),
    .KEY_REJECT  (KEY_REJECT),
    .TIMEOUT     (TIMEOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; pulses captured in the cycle after the edge, then one idle cycle
  task automatic press(input logic [3:0] code);
    @(negedge CLK);
    KEY_Value = code;
    Value_en  = 1'b1;
    @(negedge CLK);
    p_acc = KEY_ACCEPT;
    p_rej = KEY_REJECT;
    p_tmo = TIMEOUT;
    Value_en = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int acc_cnt;
    int tmo_at;
    logic early_tmo;

    checks    = 0;
    failures  = 0;
    nRST      = 1'b0;
    KEY_Value = 4'd0;
    Value_en  = 1'b0;
    ENTRY_ACK = 1'b0;
    p_acc = 1'b0;
    p_rej = 1'b0;
    p_tmo = 1'b0;

    repeat (2) @(negedge CLK);
    check("rst_bcd", 32'(ENTRY_BCD), 32'h0);
    check("rst_len", 32'(ENTRY_LEN), 32'h0);
    check("rst_pulses", {29'h0, ENTRY_VALID, KEY_ACCEPT, KEY_REJECT | TIMEOUT}, 32'h0);
    nRST = 1'b1;

    // 1,2,3,ENTER then ack
    acc_cnt = 0;
    press(4'd1); acc_cnt += int'(p_acc);
    press(4'd2); acc_cnt += int'(p_acc);
    press(4'd3); acc_cnt += int'(p_acc);
    press(4'd12); acc_cnt += int'(p_acc);
    check("enter_accepts", 32'(acc_cnt), 32'd4);
    check("enter_bcd", 32'(ENTRY_BCD), 32'h0123);
    check("enter_len", 32'(ENTRY_LEN), 32'd3);
    check("enter_valid", 32'(ENTRY_VALID), 32'd1);
    press(4'd6);
    check("done_key_rej", 32'(p_rej), 32'd1);
    check("done_key_bcd", 32'(ENTRY_BCD), 32'h0123);
    @(negedge CLK); ENTRY_ACK = 1'b1;
    @(negedge CLK); ENTRY_ACK = 1'b0;
    check("ack_valid", 32'(ENTRY_VALID), 32'd0);
    check("ack_len", 32'(ENTRY_LEN), 32'd0);
    check("ack_bcd", 32'(ENTRY_BCD), 32'h0);

    // Overflow at DIGITS
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    check("full_bcd", 32'(ENTRY_BCD), 32'h9876);
    check("full_len", 32'(ENTRY_LEN), 32'd4);
    press(4'd5);
    check("full_rej", 32'(p_rej), 32'd1);
    check("full_bcd_keep", 32'(ENTRY_BCD), 32'h9876);
    press(4'd11);
    check("clr_acc", 32'(p_acc), 32'd1);
    check("clr_len", 32'(ENTRY_LEN), 32'd0);
    press(4'd11);
    check("clr_empty_acc", 32'(p_acc), 32'd1);

    // Backspace down to empty
    press(4'd4); press(4'd5);
    check("bs_start", 32'(ENTRY_BCD), 32'h0045);
    press(4'd10);
    check("bs1_bcd", 32'(ENTRY_BCD), 32'h0004);
    check("bs1_len", 32'(ENTRY_LEN), 32'd1);
    press(4'd10);
    check("bs2_bcd", 32'(ENTRY_BCD), 32'h0000);
    check("bs2_len", 32'(ENTRY_LEN), 32'd0);
    press(4'd10);
    check("bs3_rej", {30'h0, p_acc, p_rej}, 32'd1);
    press(4'd12);
    check("enter_idle_rej", {30'h0, p_acc, p_rej}, 32'd1);

    // Held strobe yields one event
    acc_cnt = 0;
    @(negedge CLK);
    KEY_Value = 4'd7;
    Value_en  = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      acc_cnt += int'(KEY_ACCEPT);
    end
    Value_en = 1'b0;
    @(negedge CLK);
    check("held_accepts", 32'(acc_cnt), 32'd1);
    check("held_len", 32'(ENTRY_LEN), 32'd1);

    // Invalid codes in ENTRY
    press(4'd13); check("inv13_rej", {30'h0, p_acc, p_rej}, 32'd1);
    press(4'd14); check("inv14_rej", {30'h0, p_acc, p_rej}, 32'd1);
    press(4'd15); check("inv15_rej", {30'h0, p_acc, p_rej}, 32'd1);
    check("inv_bcd", 32'(ENTRY_BCD), 32'h0007);
    check("inv_len", 32'(ENTRY_LEN), 32'd1);
    press(4'd11);

    // Timeout 16 cycles after the accept
    @(negedge CLK);
    KEY_Value = 4'd3;
    Value_en  = 1'b1;
    @(negedge CLK);
    Value_en = 1'b0;
    check("to_acc", 32'(KEY_ACCEPT), 32'd1);
    tmo_at = -1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      if (TIMEOUT) begin
        tmo_at = k;
        break;
      end
    end
    check("to_cycle", 32'(tmo_at), 32'd16);
    check("to_len", 32'(ENTRY_LEN), 32'd0);
    @(negedge CLK);
    check("to_single", 32'(TIMEOUT), 32'd0);

    // Key in the expiry cycle beats the timeout
    @(negedge CLK);
    KEY_Value = 4'd3;
    Value_en  = 1'b1;
    @(negedge CLK);
    Value_en = 1'b0;
    early_tmo = 1'b0;
    repeat (15) begin
      @(negedge CLK);
      early_tmo |= TIMEOUT;
    end
    KEY_Value = 4'd4;
    Value_en  = 1'b1;
    @(negedge CLK);
    Value_en = 1'b0;
    check("race_flags", {29'h0, early_tmo, TIMEOUT, KEY_ACCEPT}, 32'd1);
    check("race_len", 32'(ENTRY_LEN), 32'd2);
    check("race_bcd", 32'(ENTRY_BCD), 32'h0034);
    press(4'd11);

    // Key together with ACK in DONE
    press(4'd1); press(4'd12);
    check("done2_valid", 32'(ENTRY_VALID), 32'd1);
    @(negedge CLK);
    KEY_Value = 4'd5;
    Value_en  = 1'b1;
    ENTRY_ACK = 1'b1;
    @(negedge CLK);
    Value_en  = 1'b0;
    ENTRY_ACK = 1'b0;
    check("ackkey_flags", {29'h0, ENTRY_VALID, KEY_ACCEPT, KEY_REJECT}, 32'd1);
    check("ackkey_len", 32'(ENTRY_LEN), 32'd0);
    @(negedge CLK);

    // Async reset with a pending entry
    press(4'd1); press(4'd2); press(4'd12);
    check("pre_rst_valid", 32'(ENTRY_VALID), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ENTRY_VALID), 32'd0);
    check("mid_rst_bcd", 32'(ENTRY_BCD), 32'h0);
    check("mid_rst_len", 32'(ENTRY_LEN), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    press(4'd8);
    check("post_rst_acc", 32'(p_acc), 32'd1);
    check("post_rst_bcd", 32'(ENTRY_BCD), 32'h0008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
- Sequences keypad key codes from the matrix keypad scanner into a multi-digit entry. The scanner supplies a 4-bit code (4*row+col) and a strobe.
- Supports digit accumulation, backspace, clear, enter and an inactivity timeout.
- Presents the completed entry as packed BCD with a valid/ack handshake to downstream logic (display driver, PIN checker).

Parameters:
DIGITS, 4, maximum digits held; legal range 1..8
TIMEOUT_CYC, 50000000, idle cycles in ENTRY before the entry is discarded; legal range 2..2^26-1
CNT_W, 26, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
KEY_Value  input  4  key code from scanner, 0..15
Value_en  input  1  key-code strobe from scanner
ENTRY_ACK  input  1  downstream has consumed ENTRY_BCD
ENTRY_BCD  output  4*DIGITS  packed digits; most recent digit in [3:0]
ENTRY_LEN  output  4  number of digits held, 0..DIGITS
ENTRY_VALID  output  1  completed entry available (level)
KEY_ACCEPT  output  1  1-cycle pulse: key acted upon
KEY_REJECT  output  1  1-cycle pulse: key ignored
TIMEOUT  output  1  1-cycle pulse: entry discarded by timeout

Behaviour:
- Reset: clock CLK; reset nRST, asynchronous, active-low.
- All outputs are 0 at reset. State is IDLE. Timeout counter is 0. Strobe-edge register is 0.
- Strobe qualification:
  - Only a rising edge of Value_en is a key event (registered previous value).
  - A Value_en held high for multiple cycles yields one event.
  - KEY_Value is sampled in the edge cycle.
- Key map:
  - Codes 0..9 are digits.
  - 10 = BACKSPACE, 11 = CLEAR, 12 = ENTER.
  - 13..15 are invalid and always produce KEY_REJECT.
- Latency: an event in cycle n updates ENTRY_BCD, ENTRY_LEN, state and the pulses in cycle n+1. All outputs are registered.
- States: IDLE (LEN=0), ENTRY (0<LEN), DONE (ENTRY_VALID=1).
- Digit in IDLE/ENTRY:
  - If LEN<DIGITS: ENTRY_BCD shifts left 4 bits with the digit in [3:0]; LEN+1; state ENTRY; KEY_ACCEPT.
  - If LEN=DIGITS: no change; KEY_REJECT.
- BACKSPACE:
  - If LEN>0: ENTRY_BCD shifts right 4 bits, zero-filled; LEN-1; next state IDLE if LEN becomes 0, else ENTRY; KEY_ACCEPT.
  - If LEN=0: KEY_REJECT.
- CLEAR in IDLE/ENTRY: ENTRY_BCD=0, LEN=0, state IDLE, KEY_ACCEPT. This applies even when already empty.
- ENTER:
  - In ENTRY: state DONE, ENTRY_VALID=1, BCD/LEN frozen; KEY_ACCEPT.
  - In IDLE: KEY_REJECT.
- DONE:
  - Every key event is rejected.
  - ENTRY_ACK=1 gives, next cycle: ENTRY_VALID=0, ENTRY_BCD=0, LEN=0, state IDLE.
  - ENTRY_ACK is ignored outside DONE.
  - A key event in the same cycle as ACK is rejected; ACK takes effect.
- Timeout:
  - The counter runs only in ENTRY.
  - It clears on any key event (accepted or rejected) and on entry to IDLE/DONE.
  - When the counter equals TIMEOUT_CYC-1 with no event that cycle: next cycle ENTRY_BCD=0, LEN=0, state IDLE, TIMEOUT pulse.
  - A key event in the expiry cycle wins: the key is processed, the counter clears, and no TIMEOUT fires.
- Pulse exclusivity: at most one of KEY_ACCEPT, KEY_REJECT, TIMEOUT is high in any cycle.
- Reset mid-operation: immediate return to reset values. A pending DONE entry is lost and ENTRY_VALID drops asynchronously.

Test Plan:
- Reset, then keys 1,2,3,ENTER(12) as single-cycle strobes:
  - BCD=0x0123, LEN=3, VALID=1, four KEY_ACCEPT pulses.
  - ACK for 1 cycle gives VALID=0, LEN=0, BCD=0 next cycle.
- DIGITS=4, keys 9,8,7,6,5:
  - BCD=0x9876, LEN=4.
  - Fifth key gives KEY_REJECT with BCD unchanged.
- Keys 4,5, BACKSPACE(10), BACKSPACE, BACKSPACE:
  - BCD 0x0045 → 0x0004 → 0x0000 with state IDLE.
  - Third backspace gives KEY_REJECT.
  - ENTER in IDLE gives KEY_REJECT.
- Value_en held high for 10 cycles with code 7: exactly one KEY_ACCEPT, LEN=1.
- Codes 13,14,15: three KEY_REJECT pulses, no state change.
- Timeout with TIMEOUT_CYC=16, then key 3 and no activity:
  - TIMEOUT pulse exactly 16 cycles after the accept cycle, with LEN=0.
  - Repeat with a key event landing in the expiry cycle: no TIMEOUT, LEN=2.
- In DONE, key 5 together with ENTRY_ACK: KEY_REJECT, VALID falls, LEN=0.
- nRST asserted mid-entry: all outputs 0 immediately.
